spi_master_multi: RTL

Parametrised SPI master that runs one full-duplex transfer of DATA_WIDTH bits, in any of the four CPOL/CPHA modes, to one of NUM_SLAVES chip selects. The serial clock is derived from the system clock by a programmable divider. It is the next-generation master for the SPI subsystem and replaces the fixed-width, single-slave master/slave pair. A host drives it through a start/busy/done_tick handshake.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_clk_gen.sv | 29 ++
 rtl/spi_master_multi.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-slave SPI master.
package spi_pkg;

  typedef enum logic [1:0] {StIdle, StLead, StXfer, StTrail} spi_state_e;

  // SPI mode encodings as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period strobe generator: one-cycle o_half_tick every CLK_DIV cycles while enabled.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_half_tick
);

  localparam int unsigned   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Held at zero while disabled so every enable starts a fresh half-period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == CNT_MAX)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_half_tick = i_en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/spi_master_multi.sv
// Multi-slave, four-mode SPI master with programmable SCLK divider.
// Define SPI_LSB_FIRST_EN to add the i_lsb_first port (LSB-first shifting).
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned CLK_DIV    = 4,
  localparam int unsigned SW        = sel_width(NUM_SLAVES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
`ifdef SPI_LSB_FIRST_EN
  input  logic                  i_lsb_first,
`endif
  input  logic [SW-1:0]         i_slave_sel,
  input  logic [DATA_WIDTH-1:0] i_m_din,
  output logic [DATA_WIDTH-1:0] o_m_dout,
  output logic                  o_busy,
  output logic                  o_done_tick,
  output logic                  o_sclk,
  output logic                  o_mosi,
  input  logic                  i_miso,
  output logic [NUM_SLAVES-1:0] o_ss_n
);

  localparam int unsigned   EW        = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
  localparam logic [EW-1:0] EDGE_DONE = EW'(2 * DATA_WIDTH);

  spi_state_e            r_state, w_state_next;
  logic [EW-1:0]         r_edge_cnt;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_m_dout;
  logic [NUM_SLAVES-1:0] r_ss_n, w_ss_sel;
  logic                  r_cpha, r_lsb, r_sclk, r_mosi, r_done;
  logic                  w_en, w_half_tick, w_accept, w_edge, w_leading, w_sample, w_shift;
  logic                  w_finish, w_lsb_in;

`ifdef SPI_LSB_FIRST_EN
  assign w_lsb_in = i_lsb_first;
`else
  assign w_lsb_in = 1'b0;
`endif

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (w_en),
    .o_half_tick(w_half_tick)
  );

  // Out-of-range selects decode to all-high: the transfer runs unaddressed.
  always_comb begin
    w_ss_sel = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (i_slave_sel == SW'(i)) w_ss_sel[i] = 1'b0;
    end
  end

  assign w_accept  = (r_state == StIdle) && i_start;
  assign w_edge    = w_half_tick &&
                     ((r_state == StLead) || ((r_state == StXfer) && (r_edge_cnt != EDGE_DONE)));
  assign w_leading = ~r_edge_cnt[0];
  assign w_sample  = w_edge && (r_cpha ? !w_leading : w_leading);
  assign w_shift   = w_edge && (r_cpha ? w_leading : (!w_leading && (r_edge_cnt != LAST_EDGE)));
  assign w_finish  = w_half_tick && (r_state == StTrail);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StLead;
      StLead:  if (w_half_tick) w_state_next = StXfer;
      StXfer:  if (w_half_tick && (r_edge_cnt == EDGE_DONE)) w_state_next = StTrail;
      StTrail: if (w_half_tick) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_en        = (r_state != StIdle);
    o_busy      = (r_state != StIdle);
    o_done_tick = r_done;
    o_sclk      = r_sclk;
    o_mosi      = r_mosi;
    o_ss_n      = r_ss_n;
    o_m_dout    = r_m_dout;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_m_dout   <= '0;
      r_ss_n     <= '1;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_cpha     <= i_cpha;
        r_lsb      <= w_lsb_in;
        r_ss_n     <= w_ss_sel;
        r_edge_cnt <= '0;
        r_rx       <= '0;
        r_sclk     <= i_cpol;
        // cpha=0 puts the first bit on the line before any SCLK edge.
        if (i_cpha) begin
          r_tx   <= i_m_din;
          r_mosi <= 1'b0;
        end else begin
          r_tx   <= w_lsb_in ? (i_m_din >> 1) : (i_m_din << 1);
          r_mosi <= w_lsb_in ? i_m_din[0] : i_m_din[DATA_WIDTH-1];
        end
      end else if (r_state == StIdle) begin
        r_sclk <= i_cpol;
      end
      if (w_edge) begin
        r_sclk     <= ~r_sclk;
        r_edge_cnt <= r_edge_cnt + EW'(1);
      end
      if (w_sample) begin
        r_rx <= r_lsb ? {i_miso, r_rx[DATA_WIDTH-1:1]} : {r_rx[DATA_WIDTH-2:0], i_miso};
      end
      if (w_shift) begin
        r_mosi <= r_lsb ? r_tx[0] : r_tx[DATA_WIDTH-1];
        r_tx   <= r_lsb ? (r_tx >> 1) : (r_tx << 1);
      end
      if (w_finish) begin
        r_ss_n   <= '1;
        r_mosi   <= 1'b0;
        r_m_dout <= r_rx;
      end
    end
  end

endmodule
